lht_update_scheduler: RTL and testbench
=======================================

LHT_UPDATE_SCHEDULER -- requirements
Module: lht_update_scheduler

Interface
REQ-001 Parameter IDX_W, default 4: width of the local history table index.
REQ-002 Parameter FIFO_DEPTH, default 4: number of pending-update slots; a power of two, at least 2.
REQ-003 Parameter NUM_ENTRIES, default 16: number of table entries swept during init; equals 2**IDX_W.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req0_valid  in  1  branch unit 0 has a resolved outcome.
REQ-007 req0_idx  in  IDX_W  table index of branch 0.
REQ-008 req0_taken  in  1  outcome of branch 0.
REQ-009 req0_ready  out  1  branch 0 update accepted this cycle when req0_valid is high.
REQ-010 req1_valid / req1_idx / req1_taken / req1_ready  same widths and meaning for branch unit 1.
REQ-011 flush  in  1  pipeline flush; discard all pending updates.
REQ-012 clear_req  in  1  request a full table re-clear.
REQ-013 lht_we  out  1  table write strobe.
REQ-014 lht_widx  out  IDX_W  table write index.
REQ-015 lht_wtaken  out  1  bit shifted into the history.
REQ-016 lht_wclr  out  1  write zero to the entry instead of shifting.
REQ-017 init_done  out  1  high in RUN state.

Function
REQ-018 Two states. INIT sweeps and clears the table. RUN forwards queued updates.
REQ-019 INIT drives lht_we=1 and lht_wclr=1 with lht_widx equal to a sweep counter counting 0..NUM_ENTRIES-1, one entry per cycle. After index NUM_ENTRIES-1 it moves to RUN, so INIT lasts exactly NUM_ENTRIES cycles.
REQ-020 In INIT: req0_ready=req1_ready=0, FIFO empty, flush has no effect.
REQ-021 clear_req sampled high in RUN moves to INIT on the next edge. The sweep counter restarts at 0, the FIFO is discarded, and requests in that cycle are not accepted. clear_req in INIT is ignored.
REQ-022 In RUN, free = FIFO_DEPTH - count, computed before this cycle's pop.
- free >= 2: req0_ready=1 and req1_ready=1.
- free == 1: only the round-robin owner's ready is 1.
- free == 0: both readies are 0.
REQ-023 Readies do not depend on valid or on the same-cycle pop.
REQ-024 The round-robin owner starts at 0 and flips to the other unit after any cycle in which the owner's request is accepted while free == 1.
REQ-025 Both requests accepted in the same cycle are enqueued req0 first, then req1.
REQ-026 In RUN with count>0: lht_we=1, lht_wclr=0, lht_widx/lht_wtaken taken from the FIFO head, and the head is popped at the edge (one write per cycle). Outputs are combinational from the head, so an update accepted in cycle N is written in cycle N+1 at the earliest.
REQ-027 With count == 0: lht_we=0, lht_wclr=0, lht_widx=0, lht_wtaken=0.
REQ-028 Simultaneous push and pop in one cycle is allowed. The count changes by pushes minus pops, and the count never exceeds FIFO_DEPTH.
REQ-029 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-030 flush high in RUN:
- both readies are forced to 0 that cycle;
- the current head write still occurs;
- all entries are discarded at the edge, so count=0 next cycle.
REQ-031 clear_req and flush high together: clear_req wins.

Reset
REQ-032 rst_n low immediately forces: state=INIT, sweep counter=0, FIFO pointers and count=0, round-robin owner=0, init_done=0.
REQ-033 The first INIT sweep begins on the first rising edge after rst_n deasserts. lht_we=1 with lht_widx=0 is visible during that first cycle after release.
REQ-034 Reset asserted mid-sweep or mid-drain abandons all pending updates. No partial write is required to complete.

Structure
REQ-035 A shared package lht_pkg holds IDX_W, FIFO_DEPTH and NUM_ENTRIES defaults, the state enum {INIT, RUN}, and the FIFO entry typedef {idx, taken}.
REQ-036 One sub-module, lht_upd_fifo, implements the two-push, one-pop FIFO with a count output. Arbitration and the FSM stay in the top module.

Verification
REQ-037 Reset release: lht_we=lht_wclr=1 with lht_widx 0..15 over 16 cycles; init_done rises in cycle 17; readies are low throughout the sweep.
REQ-038 RUN, empty FIFO, req0 (idx 5, taken 1) in cycle N: lht_we=1, lht_widx=5, lht_wtaken=1 in N+1; lht_we=0 in N+2.
REQ-039 Both units valid every cycle with distinct indices: writes appear in order req0, req1, req0, ...; readies drop when free<2; the owner alternates when free==1; no update is lost or duplicated.
REQ-040 FIFO holding 3 entries, flush asserted: one head write occurs in the flush cycle, then lht_we=0; readies are 0 in the flush cycle and return to 1 the next cycle.
REQ-041 clear_req with 2 entries queued: the next cycle shows lht_wclr=1 with lht_widx=0; the queued updates are never written; the 16-cycle sweep completes.
REQ-042 rst_n asserted at sweep index 7: outputs reset immediately; after release the sweep restarts at index 0.

Source files
------------

// File: rtl/lht_pkg.sv
// Shared types and defaults for the local history table update scheduler.
// Holds the FSM state encoding and the pending-update entry layout.
package lht_pkg;

    localparam int LHT_IDX_W       = 4;
    localparam int LHT_FIFO_DEPTH  = 4;
    localparam int LHT_NUM_ENTRIES = 1 << LHT_IDX_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } lht_state_t;

    typedef struct packed {
        logic [LHT_IDX_W-1:0] idx;
        logic                 taken;
    } lht_entry_t;

endpackage

// File: rtl/lht_upd_fifo.sv
// Pending-update queue: up to two pushes and one pop per cycle.
// Slot 0 is always filled before slot 1; clr discards everything.
module lht_upd_fifo
    import lht_pkg::*;
#(
    parameter int  DEPTH   = LHT_FIFO_DEPTH,
    parameter type entry_t = lht_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr0_en,
    input  entry_t           wr0_data,
    input  logic             wr1_en,
    input  entry_t           wr1_data,
    input  logic             rd_en,
    input  logic             clr,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [PTR_W-1:0] wp_p1;
    logic [PTR_W-1:0] wp_nxt;
    logic [PTR_W-1:0] rp_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [1:0]       n_push;

    assign head  = mem[rp];
    assign wp_p1 = wp + PTR_W'(1);

    // Pointer and occupancy arithmetic; pointers wrap naturally
    always_comb begin
        n_push    = {1'b0, wr0_en} + {1'b0, wr1_en};
        wp_nxt    = wp + PTR_W'(n_push);
        rp_nxt    = rp + PTR_W'(rd_en);
        count_nxt = count + CNT_W'(n_push) - CNT_W'(rd_en);
    end

    // Storage array; contents need no reset since count gates use
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wp]    <= wr0_data;
        if (wr1_en) mem[wp_p1] <= wr1_data;
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp_nxt;
            rp    <= rp_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/lht_update_scheduler.sv
// Local history table update scheduler: clears the table after reset
// or on request, then merges two branch units' updates into one port.
module lht_update_scheduler
    import lht_pkg::*;
#(
    parameter int IDX_W       = LHT_IDX_W,
    parameter int FIFO_DEPTH  = LHT_FIFO_DEPTH,
    parameter int NUM_ENTRIES = LHT_NUM_ENTRIES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [IDX_W-1:0] req0_idx,
    input  logic             req0_taken,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IDX_W-1:0] req1_idx,
    input  logic             req1_taken,
    output logic             req1_ready,
    input  logic             flush,
    input  logic             clear_req,
    output logic             lht_we,
    output logic [IDX_W-1:0] lht_widx,
    output logic             lht_wtaken,
    output logic             lht_wclr,
    output logic             init_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    lht_state_t       state;
    lht_state_t       state_nxt;
    logic [IDX_W-1:0] sweep;
    logic [IDX_W-1:0] sweep_nxt;
    logic             owner;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    upd_t             head;
    upd_t             e0;
    upd_t             e1;
    upd_t             wr0_data;
    logic             run;
    logic             blocked;
    logic             two_free;
    logic             one_free;
    logic             acc0;
    logic             acc1;
    logic             wr0_en;
    logic             wr1_en;
    logic             pop;
    logic             fifo_clr;
    logic             sweep_end;

    assign run       = (state == RUN);
    assign init_done = run;
    assign sweep_end = (sweep == LAST_IDX);

    // Free slots are judged before this cycle's pop
    assign free     = DEPTH_C - count;
    assign two_free = (free >= CNT_W'(2));
    assign one_free = (free == CNT_W'(1));
    assign blocked  = !run || flush || clear_req;

    assign e0 = {req0_idx, req0_taken};
    assign e1 = {req1_idx, req1_taken};

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;

    // A lone req1 takes the first slot so slots stay contiguous
    assign wr0_en   = acc0 || acc1;
    assign wr0_data = acc0 ? e0 : e1;
    assign wr1_en   = acc0 && acc1;

    assign pop      = run && (count != '0);
    assign fifo_clr = run && (flush || clear_req);

    // State and sweep counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            sweep <= sweep_nxt;
        end
    end

    // Next state: sweep once through the table, leave RUN on clear
    always_comb begin
        state_nxt = state;
        sweep_nxt = '0;
        unique case (state)
            INIT: begin
                if (sweep_end) begin
                    state_nxt = RUN;
                end else begin
                    sweep_nxt = sweep + IDX_W'(1);
                end
            end
            RUN: begin
                if (clear_req) state_nxt = INIT;
            end
            default: ;
        endcase
    end

    // Table write port: clear sweep in INIT, queue head in RUN
    always_comb begin
        lht_we     = 1'b0;
        lht_wclr   = 1'b0;
        lht_widx   = '0;
        lht_wtaken = 1'b0;
        unique case (state)
            INIT: begin
                lht_we   = 1'b1;
                lht_wclr = 1'b1;
                lht_widx = sweep;
            end
            RUN: begin
                if (count != '0) begin
                    lht_we     = 1'b1;
                    lht_widx   = head.idx;
                    lht_wtaken = head.taken;
                end
            end
            default: ;
        endcase
    end

    // Readies from occupancy only; last slot goes to the owner
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!blocked) begin
            unique case (1'b1)
                two_free: begin
                    req0_ready = 1'b1;
                    req1_ready = 1'b1;
                end
                one_free: begin
                    req0_ready = !owner;
                    req1_ready = owner;
                end
                default: ;
            endcase
        end
    end

    // Owner hands the last slot over once it has used it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 1'b0;
        end else if (one_free && (acc0 || acc1)) begin
            owner <= !owner;
        end
    end

    lht_upd_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (upd_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (e1),
        .rd_en    (pop),
        .clr      (fifo_clr),
        .head     (head),
        .count    (count)
    );

endmodule

// File: tb/tb_lht_update_scheduler.sv
// Bench for lht_update_scheduler: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_lht_update_scheduler;

    localparam int IW = 4;
    localparam int DEPTH = 4;
    localparam int NE = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_taken, req0_ready;
    logic [IW-1:0] req0_idx;
    logic          req1_valid, req1_taken, req1_ready;
    logic [IW-1:0] req1_idx;
    logic          flush, clear_req;
    logic          lht_we, lht_wtaken, lht_wclr, init_done;
    logic [IW-1:0] lht_widx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        bit taken;
    } ent_t;

    ent_t q[$];
    bit   m_init = 1'b1;
    int   m_sweep = 0;
    bit   m_owner = 1'b0;

    always #5 clk = ~clk;

    lht_update_scheduler #(
        .IDX_W       (IW),
        .FIFO_DEPTH  (DEPTH),
        .NUM_ENTRIES (NE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_idx   (req0_idx),
        .req0_taken (req0_taken),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_idx   (req1_idx),
        .req1_taken (req1_taken),
        .req1_ready (req1_ready),
        .flush      (flush),
        .clear_req  (clear_req),
        .lht_we     (lht_we),
        .lht_widx   (lht_widx),
        .lht_wtaken (lht_wtaken),
        .lht_wclr   (lht_wclr),
        .init_done  (init_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: compare current cycle, then advance past the edge
    always @(negedge clk) begin
        int   free;
        bit   er0, er1, ewe, ewclr, ewt, edone, a0, a1;
        int   ewidx;
        ent_t e;
        if (!rst_n) begin
            m_init  = 1'b1;
            m_sweep = 0;
            m_owner = 1'b0;
            q.delete();
        end
        free = DEPTH - q.size();
        er0 = 1'b0;
        er1 = 1'b0;
        ewt = 1'b0;
        ewidx = 0;
        if (m_init) begin
            ewe = 1'b1;
            ewclr = 1'b1;
            ewidx = m_sweep;
            edone = 1'b0;
        end else begin
            edone = 1'b1;
            ewclr = 1'b0;
            ewe = (q.size() > 0);
            if (ewe) begin
                ewidx = q[0].idx;
                ewt = q[0].taken;
            end
            if (!flush && !clear_req) begin
                if (free >= 2) begin
                    er0 = 1'b1;
                    er1 = 1'b1;
                end else if (free == 1) begin
                    er0 = !m_owner;
                    er1 = m_owner;
                end
            end
        end
        chk("m_we", int'(lht_we), int'(ewe));
        chk("m_wclr", int'(lht_wclr), int'(ewclr));
        chk("m_widx", int'(lht_widx), ewidx);
        chk("m_wtaken", int'(lht_wtaken), int'(ewt));
        chk("m_rdy0", int'(req0_ready), int'(er0));
        chk("m_rdy1", int'(req1_ready), int'(er1));
        chk("m_done", int'(init_done), int'(edone));
        if (rst_n) begin
            if (m_init) begin
                if (m_sweep == NE - 1) m_init = 1'b0;
                m_sweep = (m_sweep + 1) % NE;
            end else begin
                a0 = req0_valid && er0;
                a1 = req1_valid && er1;
                if (q.size() > 0) void'(q.pop_front());
                if (a0) begin
                    e.idx = int'(req0_idx);
                    e.taken = req0_taken;
                    q.push_back(e);
                end
                if (a1) begin
                    e.idx = int'(req1_idx);
                    e.taken = req1_taken;
                    q.push_back(e);
                end
                if (free == 1 && (a0 || a1)) m_owner = !m_owner;
                if (clear_req) begin
                    m_init = 1'b1;
                    m_sweep = 0;
                    q.delete();
                end else if (flush) begin
                    q.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush = 1'b0;
        clear_req = 1'b0;
    endtask

    initial begin
        int i0;
        rst_n = 1'b0;
        idle();
        req0_idx = '0;
        req1_idx = '0;
        req0_taken = 1'b0;
        req1_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sweep after reset release
        for (int i = 0; i < NE; i++) begin
            @(negedge clk);
            chk("sweep_we", int'(lht_we && lht_wclr), 1);
            chk("sweep_idx", int'(lht_widx), i);
            chk("sweep_rdy", int'({req0_ready, req1_ready}), 0);
            chk("sweep_done", int'(init_done), 0);
        end
        @(negedge clk);
        chk("done_rise", int'(init_done), 1);

        // Single update latency
        step();
        req0_valid = 1'b1;
        req0_idx = 4'd5;
        req0_taken = 1'b1;
        @(negedge clk);
        chk("lat_rdy", int'(req0_ready), 1);
        step();
        idle();
        @(negedge clk);
        chk("lat_we", int'(lht_we), 1);
        chk("lat_widx", int'(lht_widx), 5);
        chk("lat_taken", int'(lht_wtaken), 1);
        step();
        @(negedge clk);
        chk("lat_we_off", int'(lht_we), 0);

        // Flush with three entries queued
        step();
        req0_valid = 1'b1; req0_idx = 4'd1; req0_taken = 1'b0;
        req1_valid = 1'b1; req1_idx = 4'd2; req1_taken = 1'b1;
        step();
        req0_idx = 4'd3;
        req1_idx = 4'd4;
        step();
        idle();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_rdy", int'({req0_ready, req1_ready}), 0);
        chk("fl_we", int'(lht_we), 1);
        chk("fl_widx", int'(lht_widx), 2);
        chk("fl_taken", int'(lht_wtaken), 1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_after_we", int'(lht_we), 0);
        chk("fl_after_rdy", int'({req0_ready, req1_ready}), 3);

        // Clear with two entries queued
        step();
        req0_valid = 1'b1; req0_idx = 4'd9; req0_taken = 1'b1;
        req1_valid = 1'b1; req1_idx = 4'd10; req1_taken = 1'b0;
        step();
        idle();
        clear_req = 1'b1;
        @(negedge clk);
        chk("clr_head_we", int'(lht_we), 1);
        chk("clr_head_idx", int'(lht_widx), 9);
        step();
        clear_req = 1'b0;
        for (int i = 0; i < NE; i++) begin
            @(negedge clk);
            chk("clr_wclr", int'(lht_wclr), 1);
            chk("clr_idx", int'(lht_widx), i);
        end
        @(negedge clk);
        chk("clr_done", int'(init_done), 1);

        // Both units saturating with distinct indices
        for (int n = 0; n < 300; n++) begin
            step();
            i0 = $urandom_range(0, NE - 1);
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_idx = IW'(i0);
            req1_idx = IW'((i0 + 1 + $urandom_range(0, NE - 2)) % NE);
            req0_taken = 1'($urandom_range(0, 1));
            req1_taken = 1'($urandom_range(0, 1));
        end

        // Random traffic with flushes and clears
        for (int n = 0; n < 1500; n++) begin
            step();
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_idx = IW'($urandom_range(0, NE - 1));
            req1_idx = IW'($urandom_range(0, NE - 1));
            req0_taken = 1'($urandom_range(0, 1));
            req1_taken = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 19) == 0);
            clear_req = ($urandom_range(0, 99) == 0);
        end
        step();
        idle();
        repeat (20) step();

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (7) step();
        #1;
        chk("mid_idx", int'(lht_widx), 7);
        rst_n = 1'b0;
        #1;
        chk("rst_idx", int'(lht_widx), 0);
        chk("rst_we", int'(lht_we && lht_wclr), 1);
        chk("rst_done", int'(init_done), 0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_idx", int'(lht_widx), 0);
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
